// File: rtl/alu16_exec_ctrl.sv
// Issue/capture stage around the combinational 16-bit ALU.
// Holds operands for a per-op cycle count, captures result/cc, and keeps NZCV flags.
module alu16_exec_ctrl #(
  parameter int BASE_CYCLES = 1,
  parameter int MUL_CYCLES  = 4,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic        in_dir,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  output logic [15:0] alu_valA,
  output logic [15:0] alu_valB,
  output logic [3:0]  alu_aluop,
  output logic        alu_sub,
  output logic        alu_shift_dir,
  output logic        alu_rot_dir,
  input  logic [15:0] alu_result,
  input  logic [3:0]  alu_cc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_result,
  output logic [3:0]  out_cc,
  output logic        out_err,
  output logic [3:0]  flags,
  output logic        busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_BASE = CNT_W'(BASE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MUL  = CNT_W'(MUL_CYCLES);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_accept;
  logic             w_illegal;

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign w_accept  = in_valid && (r_state == S_IDLE);
  assign w_illegal = (in_op >= 4'd12);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      alu_valA      <= '0;
      alu_valB      <= '0;
      alu_aluop     <= '0;
      alu_sub       <= 1'b0;
      alu_shift_dir <= 1'b0;
      alu_rot_dir   <= 1'b0;
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_cc        <= '0;
      out_err       <= 1'b0;
      flags         <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            alu_valA      <= in_a;
            alu_valB      <= in_b;
            alu_aluop     <= in_op;
            alu_shift_dir <= in_dir;
            alu_sub       <= (in_op == 4'd1);
            alu_rot_dir   <= (in_op == 4'd6);
            // Illegal opcodes never reach the ALU capture path.
            if (w_illegal) begin
              out_result <= '0;
              out_cc     <= 4'b0100;
              out_err    <= 1'b1;
              out_valid  <= 1'b1;
              r_state    <= S_DONE;
            end else begin
              r_cnt   <= (in_op == 4'd7) ? CNT_MUL : CNT_BASE;
              r_state <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          r_cnt <= r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) begin
            out_result <= alu_result;
            out_cc     <= alu_cc;
            out_err    <= 1'b0;
            out_valid  <= 1'b1;
            r_state    <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (!out_err) flags <= out_cc;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
